load_use_hazard_unit: RTL and testbench

- Detects RV32IM load-use hazards between the load in EX and the dependent instruction in ID.
- Stalls PC and IF/ID, and injects one bubble into ID/EX.
- When the dependent instruction reaches EX, drives LOAD_USE_RS1/LOAD_USE_RS2 = 2'b01 (forward from MEM/WB) into the downstream load-use forwarding comparator.
- Keeps a saturating stall-cycle counter for performance debug.

---
 rtl/load_use_hazard_unit_pkg.sv | 15 +
 rtl/load_use_hazard_unit_if.sv | 40 ++++
 rtl/load_use_hazard_unit_match.sv | 28 ++
 rtl/load_use_hazard_unit.sv | 120 ++++++++++++
 tb/tb_load_use_hazard_unit.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/load_use_hazard_unit_pkg.sv
// Shared encodings for the load-use hazard unit and the forwarding comparator.
// FSM state codes are kept as plain vectors so legacy netlists can reuse them.
package load_use_hazard_unit_pkg;

  localparam logic [1:0] FWD_NONE  = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  localparam int REG_X0 = 0;

  typedef logic [1:0] state_t;
  localparam state_t IDLE    = 2'd0;
  localparam state_t BUBBLE  = 2'd1;
  localparam state_t FORWARD = 2'd2;

endpackage

// File: rtl/load_use_hazard_unit_if.sv
// Pipeline-side bundle for the load-use hazard unit: ID/EX operand info in,
// stall/bubble controls and forward overrides out.
interface load_use_hazard_unit_if #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int COUNT_WIDTH    = 16
);
  logic [REG_ADDR_WIDTH-1:0] ID_RS1_ADDR;
  logic [REG_ADDR_WIDTH-1:0] ID_RS2_ADDR;
  logic                      ID_RS1_USED;
  logic                      ID_RS2_USED;
  logic                      ID_VALID;
  logic [REG_ADDR_WIDTH-1:0] EX_RD_ADDR;
  logic                      EX_MEM_READ;
  logic                      EX_REG_WRITE;
  logic                      DMEM_BUSY;
  logic                      BRANCH_FLUSH;
  logic                      STALL_COUNT_CLR;
  logic                      PC_WRITE_EN;
  logic                      IF_ID_WRITE_EN;
  logic                      ID_EX_BUBBLE;
  logic [1:0]                LOAD_USE_RS1;
  logic [1:0]                LOAD_USE_RS2;
  logic [COUNT_WIDTH-1:0]    STALL_COUNT;

  modport master (
    output ID_RS1_ADDR, ID_RS2_ADDR, ID_RS1_USED, ID_RS2_USED, ID_VALID,
           EX_RD_ADDR, EX_MEM_READ, EX_REG_WRITE, DMEM_BUSY, BRANCH_FLUSH,
           STALL_COUNT_CLR,
    input  PC_WRITE_EN, IF_ID_WRITE_EN, ID_EX_BUBBLE, LOAD_USE_RS1,
           LOAD_USE_RS2, STALL_COUNT
  );

  modport slave (
    input  ID_RS1_ADDR, ID_RS2_ADDR, ID_RS1_USED, ID_RS2_USED, ID_VALID,
           EX_RD_ADDR, EX_MEM_READ, EX_REG_WRITE, DMEM_BUSY, BRANCH_FLUSH,
           STALL_COUNT_CLR,
    output PC_WRITE_EN, IF_ID_WRITE_EN, ID_EX_BUBBLE, LOAD_USE_RS1,
           LOAD_USE_RS2, STALL_COUNT
  );
endinterface

// File: rtl/load_use_hazard_unit_match.sv
// Combinational compare of the EX load destination against the ID sources.
// Zero latency; x0 is never a hazard because it is hard-wired to zero.
module load_use_match
  import load_use_hazard_unit_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] i_id_rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] i_id_rs2_addr,
  input  logic                      i_id_rs1_used,
  input  logic                      i_id_rs2_used,
  input  logic                      i_id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] i_ex_rd_addr,
  input  logic                      i_ex_mem_read,
  input  logic                      i_ex_reg_write,
  output logic                      o_m1,
  output logic                      o_m2
);

  logic w_ex_load_wr;

  assign w_ex_load_wr = i_id_valid & i_ex_mem_read & i_ex_reg_write &
                        (i_ex_rd_addr != REG_ADDR_WIDTH'(REG_X0));

  assign o_m1 = w_ex_load_wr & i_id_rs1_used & (i_ex_rd_addr == i_id_rs1_addr);
  assign o_m2 = w_ex_load_wr & i_id_rs2_used & (i_ex_rd_addr == i_id_rs2_addr);

endmodule

// File: rtl/load_use_hazard_unit.sv
// Load-use hazard FSM: combinational stall + one bubble, then a one-cycle
// MEM/WB forward override when the consumer reaches EX; saturating stall counter.
module load_use_hazard_unit
  import load_use_hazard_unit_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  load_use_hazard_unit_if.slave bus
);

  state_t                 r_state;
  state_t                 w_next_state;
  logic                   r_r1;
  logic                   r_r2;
  logic                   w_r1_next;
  logic                   w_r2_next;
  logic                   w_m1;
  logic                   w_m2;
  logic                   w_haz;
  logic                   w_stall;
  logic                   w_hold;
  logic [1:0]             w_lu_rs1;
  logic [1:0]             w_lu_rs2;
  logic [COUNT_WIDTH-1:0] r_stall_count;

  load_use_match #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_match (
    .i_id_rs1_addr (bus.ID_RS1_ADDR),
    .i_id_rs2_addr (bus.ID_RS2_ADDR),
    .i_id_rs1_used (bus.ID_RS1_USED),
    .i_id_rs2_used (bus.ID_RS2_USED),
    .i_id_valid    (bus.ID_VALID),
    .i_ex_rd_addr  (bus.EX_RD_ADDR),
    .i_ex_mem_read (bus.EX_MEM_READ),
    .i_ex_reg_write(bus.EX_REG_WRITE),
    .o_m1          (w_m1),
    .o_m2          (w_m2)
  );

  assign w_haz = w_m1 | w_m2;

  always_comb begin
    w_next_state = r_state;
    w_r1_next    = r_r1;
    w_r2_next    = r_r2;
    w_stall      = 1'b0;
    w_lu_rs1     = FWD_NONE;
    w_lu_rs2     = FWD_NONE;
    case (r_state)
      IDLE: begin
        if (w_haz) begin
          w_stall      = 1'b1;
          w_r1_next    = w_m1;
          w_r2_next    = w_m2;
          w_next_state = BUBBLE;
        end
      end
      BUBBLE: begin
        if (bus.DMEM_BUSY) w_stall = 1'b1;
        else               w_next_state = FORWARD;
      end
      FORWARD: begin
        w_lu_rs1 = r_r1 ? FWD_MEMWB : FWD_NONE;
        w_lu_rs2 = r_r2 ? FWD_MEMWB : FWD_NONE;
        if (w_haz) begin
          w_stall      = 1'b1;
          w_r1_next    = w_m1;
          w_r2_next    = w_m2;
          w_next_state = BUBBLE;
        end else begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
    // Flush logic owns PC/IF_ID/ID_EX this cycle; the EX consumer predates the
    // branch, so the forward override above is intentionally left untouched.
    if (bus.BRANCH_FLUSH) begin
      w_stall      = 1'b0;
      w_r1_next    = 1'b0;
      w_r2_next    = 1'b0;
      w_next_state = IDLE;
    end
  end

  // Gate with reset so outputs return to idle values asynchronously.
  assign w_hold = w_stall & RESET_N;

  assign bus.PC_WRITE_EN    = ~w_hold;
  assign bus.IF_ID_WRITE_EN = ~w_hold;
  assign bus.ID_EX_BUBBLE   = w_hold;
  assign bus.LOAD_USE_RS1   = RESET_N ? w_lu_rs1 : FWD_NONE;
  assign bus.LOAD_USE_RS2   = RESET_N ? w_lu_rs2 : FWD_NONE;
  assign bus.STALL_COUNT    = r_stall_count;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= IDLE;
      r_r1    <= 1'b0;
      r_r2    <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_r1    <= w_r1_next;
      r_r2    <= w_r2_next;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_stall_count <= '0;
    end else if (bus.STALL_COUNT_CLR) begin
      r_stall_count <= '0;
    end else if (w_hold && !(&r_stall_count)) begin
      r_stall_count <= r_stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_load_use_hazard_unit.sv
// Directed bench for load_use_hazard_unit: hazard detection, stall/bubble,
// forward override timing, flush, async reset and counter saturation/clear.
module tb_load_use_hazard_unit;

  logic CLK;
  logic RESET_N;
  int   n_tests;
  int   n_fail;

  load_use_hazard_unit_if #(.REG_ADDR_WIDTH(5), .COUNT_WIDTH(16)) bus ();

  load_use_hazard_unit #(.REG_ADDR_WIDTH(5), .COUNT_WIDTH(16)) dut (
    .CLK    (CLK),
    .RESET_N(RESET_N),
    .bus    (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected PC/IF_ID enable, bubble and both forward selects.
  task automatic chk_out(input string tag, input logic en, input logic bub,
                         input logic [1:0] lu1, input logic [1:0] lu2);
    chk({tag, ".pc_en"},  {31'd0, bus.PC_WRITE_EN},    {31'd0, en});
    chk({tag, ".ifid_en"}, {31'd0, bus.IF_ID_WRITE_EN}, {31'd0, en});
    chk({tag, ".bubble"}, {31'd0, bus.ID_EX_BUBBLE},   {31'd0, bub});
    chk({tag, ".lu_rs1"}, {30'd0, bus.LOAD_USE_RS1},   {30'd0, lu1});
    chk({tag, ".lu_rs2"}, {30'd0, bus.LOAD_USE_RS2},   {30'd0, lu2});
  endtask

  task automatic chk_cnt(input string tag, input logic [15:0] exp);
    chk({tag, ".count"}, {16'd0, bus.STALL_COUNT}, {16'd0, exp});
  endtask

  // valid, rs1, rs1_used, rs2, rs2_used, ex_rd, ex_is_load, busy, flush
  task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                       input logic ld, input logic busy, input logic flush);
    bus.ID_VALID     = v;
    bus.ID_RS1_ADDR  = rs1;
    bus.ID_RS1_USED  = u1;
    bus.ID_RS2_ADDR  = rs2;
    bus.ID_RS2_USED  = u2;
    bus.EX_RD_ADDR   = rd;
    bus.EX_MEM_READ  = ld;
    bus.EX_REG_WRITE = ld;
    bus.DMEM_BUSY    = busy;
    bus.BRANCH_FLUSH = flush;
    #1;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    RESET_N = 1'b0;
    bus.STALL_COUNT_CLR = 1'b0;

    // Reset with a live hazard on the inputs: outputs must still be idle.
    drive(1, 5'd5, 1, 5'd0, 0, 5'd5, 1, 0, 0);
    chk_out("reset", 1, 0, 2'b00, 2'b00);
    chk_cnt("reset", 16'd0);
    tick();
    tick();
    drive(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0);
    RESET_N = 1'b1;
    tick();
    chk_out("post_reset", 1, 0, 2'b00, 2'b00);

    // Basic load x5 -> add rs1=x5.
    drive(1, 5'd5, 1, 5'd6, 1, 5'd5, 1, 0, 0);
    chk_out("basic.c0", 0, 1, 2'b00, 2'b00);
    tick();
    drive(1, 5'd5, 1, 5'd6, 1, 5'd0, 0, 0, 0);
    chk_out("basic.c1", 1, 0, 2'b00, 2'b00);
    tick();
    drive(1, 5'd9, 1, 5'd10, 1, 5'd7, 0, 0, 0);
    chk_out("basic.c2", 1, 0, 2'b01, 2'b00);
    tick();
    drive(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0);
    chk_out("basic.c3", 1, 0, 2'b00, 2'b00);
    chk_cnt("basic", 16'd1);

    // No hazard: x0 destination, and rs2 match that is not used.
    drive(1, 5'd0, 1, 5'd0, 1, 5'd0, 1, 0, 0);
    chk_out("x0", 1, 0, 2'b00, 2'b00);
    drive(1, 5'd3, 1, 5'd7, 0, 5'd7, 1, 0, 0);
    chk_out("rs2_unused", 1, 0, 2'b00, 2'b00);
    tick();
    drive(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0);
    chk_out("nohaz.next", 1, 0, 2'b00, 2'b00);
    chk_cnt("nohaz", 16'd1);

    // Clear, then load x3 feeding both sources with DMEM_BUSY for 2 cycles.
    bus.STALL_COUNT_CLR = 1'b1;
    tick();
    bus.STALL_COUNT_CLR = 1'b0;
    chk_cnt("clr", 16'd0);
    drive(1, 5'd3, 1, 5'd3, 1, 5'd3, 1, 0, 0);
    chk_out("busy.c0", 0, 1, 2'b00, 2'b00);
    tick();
    drive(1, 5'd3, 1, 5'd3, 1, 5'd0, 0, 1, 0);
    chk_out("busy.c1", 0, 1, 2'b00, 2'b00);
    tick();
    chk_out("busy.c2", 0, 1, 2'b00, 2'b00);
    tick();
    drive(1, 5'd3, 1, 5'd3, 1, 5'd0, 0, 0, 0);
    chk_out("busy.c3", 1, 0, 2'b00, 2'b00);
    tick();
    drive(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0);
    chk_out("busy.c4", 1, 0, 2'b01, 2'b01);
    tick();
    chk_out("busy.c5", 1, 0, 2'b00, 2'b00);
    chk_cnt("busy", 16'd3);

    // lw x1; lw x2,0(x1); add x?, x4, x2.
    drive(1, 5'd1, 1, 5'd0, 0, 5'd1, 1, 0, 0);
    chk_out("b2b.c0", 0, 1, 2'b00, 2'b00);
    tick();
    drive(1, 5'd1, 1, 5'd0, 0, 5'd0, 0, 0, 0);
    chk_out("b2b.c1", 1, 0, 2'b00, 2'b00);
    tick();
    drive(1, 5'd4, 1, 5'd2, 1, 5'd2, 1, 0, 0);
    chk_out("b2b.c2", 0, 1, 2'b01, 2'b00);
    tick();
    drive(1, 5'd4, 1, 5'd2, 1, 5'd0, 0, 0, 0);
    chk_out("b2b.c3", 1, 0, 2'b00, 2'b00);
    tick();
    drive(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0);
    chk_out("b2b.c4", 1, 0, 2'b00, 2'b01);
    tick();
    chk_out("b2b.c5", 1, 0, 2'b00, 2'b00);
    chk_cnt("b2b", 16'd5);

    // Flush while in BUBBLE (busy): stall released, no later override.
    drive(1, 5'd5, 1, 5'd0, 0, 5'd5, 1, 0, 0);
    tick();
    drive(1, 5'd5, 1, 5'd0, 0, 5'd0, 0, 1, 1);
    chk_out("flush_bub.c1", 1, 0, 2'b00, 2'b00);
    tick();
    drive(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0);
    chk_out("flush_bub.c2", 1, 0, 2'b00, 2'b00);
    tick();
    chk_out("flush_bub.c3", 1, 0, 2'b00, 2'b00);

    // Flush in FORWARD: override still reflects the older EX consumer.
    drive(1, 5'd0, 0, 5'd8, 1, 5'd8, 1, 0, 0);
    tick();
    drive(1, 5'd0, 0, 5'd8, 1, 5'd0, 0, 0, 0);
    tick();
    drive(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1);
    chk_out("flush_fwd", 1, 0, 2'b00, 2'b01);
    tick();
    drive(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0);
    chk_out("flush_fwd.next", 1, 0, 2'b00, 2'b00);
    chk_cnt("flush", 16'd7);

    // Async reset in the middle of a busy BUBBLE.
    drive(1, 5'd5, 1, 5'd0, 0, 5'd5, 1, 0, 0);
    tick();
    drive(1, 5'd5, 1, 5'd0, 0, 5'd0, 0, 1, 0);
    chk_out("rst_mid.pre", 0, 1, 2'b00, 2'b00);
    #2;
    RESET_N = 1'b0;
    #1;
    chk_out("rst_mid", 1, 0, 2'b00, 2'b00);
    chk_cnt("rst_mid", 16'd0);
    tick();
    drive(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0);
    RESET_N = 1'b1;
    tick();
    chk_out("rst_mid.after", 1, 0, 2'b00, 2'b00);

    // Saturation: hold a busy stall past 16'hFFFF cycles.
    drive(1, 5'd6, 1, 5'd0, 0, 5'd6, 1, 0, 0);
    tick();
    drive(1, 5'd6, 1, 5'd0, 0, 5'd0, 0, 1, 0);
    for (int i = 0; i < 65540; i++) tick();
    chk_out("sat", 0, 1, 2'b00, 2'b00);
    chk_cnt("sat", 16'hFFFF);
    tick();
    chk_cnt("sat.hold", 16'hFFFF);
    bus.STALL_COUNT_CLR = 1'b1;
    tick();
    bus.STALL_COUNT_CLR = 1'b0;
    chk_out("clr_stall", 0, 1, 2'b00, 2'b00);
    chk_cnt("clr_stall", 16'd0);
    tick();
    chk_cnt("after_clr", 16'd1);
    drive(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0);
    tick();
    chk_out("sat.fwd", 1, 0, 2'b01, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
